module_deco_gray_nseg: RTL and testbench

//  - Parametrised Gray-to-binary decoder. Drives an N-digit multiplexed 7-segment display and a binary LED bank.
//  - Synchronises and periodically samples a GRAY_W-bit switch input, then converts it to binary.
//  - Converts binary to BCD sequentially (double-dabble, one bit per cycle) and scans DIGITS anodes.
//  - Board-level top; sits directly on switches, LEDs and the display.

---
 rtl/deco_gray_pkg.sv | 55 +++++
 rtl/module_deco_gray_nseg_bin2bcd.sv | 66 ++++++
 rtl/module_deco_gray_nseg.sv | 128 ++++++++++++
 tb/tb_module_deco_gray_nseg.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/deco_gray_pkg.sv
// Shared constants for the Gray decoder display: segment patterns, FSM encoding and conversion helpers.
package deco_gray_pkg;

  // Segment patterns {g,f,e,d,c,b,a}, active-low
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_LOAD = 2'd2
  } state_t;

  // Binary bit i is the XOR of all Gray bits at or above i within the w-bit word.
  function automatic logic [31:0] gray2bin(input logic [31:0] g, input int w);
    logic [31:0] mask;
    logic [31:0] gm;
    logic [31:0] b;
    mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    gm   = g & mask;
    b    = '0;
    for (int i = 0; i < 32; i++) begin
      b[i] = ^(gm >> i);
    end
    return b;
  endfunction

  function automatic logic [6:0] seg_of(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/module_deco_gray_nseg_bin2bcd.sv
// Sequential double-dabble converter: one binary bit shifted into the BCD accumulator per cycle.
module module_bin2bcd_seq
  import deco_gray_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [BIN_W-1:0]      bin_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [4*DIGITS-1:0]   bcd_o
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = (BIN_W > 2) ? $clog2(BIN_W) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BIN_W - 1);

  logic [BIN_W-1:0] sh_q, sh_d;
  logic [BCD_W-1:0] bcd_q, bcd_d, adj;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             act_q, act_d;

  always_comb begin
    adj = bcd_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end
    sh_d  = sh_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    act_d = act_q;
    if (start_i && !act_q) begin
      sh_d  = bin_i;
      bcd_d = '0;
      cnt_d = '0;
      act_d = 1'b1;
    end else if (act_q) begin
      bcd_d = {adj[BCD_W-2:0], sh_q[BIN_W-1]};
      sh_d  = sh_q << 1;
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == LAST) act_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sh_q  <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      act_q <= 1'b0;
    end else begin
      sh_q  <= sh_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
      act_q <= act_d;
    end
  end

  assign busy_o = act_q;
  assign done_o = act_q && (cnt_q == LAST);
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/module_deco_gray_nseg.sv
// Board top: synchronised, periodically sampled Gray switches -> binary LEDs and a scanned N-digit display.
// Define DECO_GRAY_BLANK_EN to blank leading-zero digits (digit 0 is always shown).
module module_deco_gray_nseg
  import deco_gray_pkg::*;
#(
  parameter int GRAY_W    = 8,
  parameter int DIGITS    = 3,
  parameter int REFRESH_W = 16,
  parameter int SAMPLE_W  = 20
) (
  input  logic              clk_pi,
  input  logic              rst_pi,
  input  logic [GRAY_W-1:0] codigo_gray_pi,
  output logic [DIGITS-1:0] anodo_po,
  output logic [6:0]        catodo_po,
  output logic [GRAY_W-1:0] codigo_bin_led_po,
  output logic              conv_busy_po,
  output logic              dato_listo_po
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [GRAY_W-1:0]    sync1_q, sync2_q, bin_lat_q, led_q, bin_now;
  logic [SAMPLE_W-1:0]  samp_q;
  logic [REFRESH_W-1:0] ref_q;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [BCD_W-1:0]     disp_q, bcd_w;
  logic [DIGITS-1:0]    anodo_q;
  logic [6:0]           catodo_q, seg_d;
  logic [3:0]           nib;
  logic [31:0]          bin_full;
  logic                 tick_q, conv_start, conv_busy, conv_done, unused_bin_hi;
  state_t               state_q, state_d;

  assign bin_full      = gray2bin(32'(sync2_q), GRAY_W);
  assign bin_now       = bin_full[GRAY_W-1:0];
  assign unused_bin_hi = ^bin_full[31:GRAY_W];

  module_bin2bcd_seq #(.BIN_W(GRAY_W), .DIGITS(DIGITS)) u_bin2bcd (
    .clk_i   (clk_pi),
    .rst_i   (rst_pi),
    .start_i (conv_start),
    .bin_i   (bin_now),
    .busy_o  (conv_busy),
    .done_o  (conv_done),
    .bcd_o   (bcd_w)
  );

  // Ticks arriving outside S_IDLE are simply not looked at, so they are dropped.
  always_comb begin
    state_d    = state_q;
    conv_start = 1'b0;
    case (state_q)
      S_IDLE: if (tick_q) begin
        conv_start = 1'b1;
        state_d    = S_CONV;
      end
      S_CONV: if (conv_done) state_d = S_LOAD;
      S_LOAD: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_pi) begin
    if (rst_pi) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    nib = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (IDX_W'(k) == idx_q) nib = disp_q[4*k +: 4];
    end
    seg_d = seg_of(nib);
`ifdef DECO_GRAY_BLANK_EN
    begin
      logic upper_zero;
      upper_zero = 1'b1;
      for (int k = 0; k < DIGITS; k++) begin
        if (IDX_W'(k) >= idx_q && disp_q[4*k +: 4] != 4'd0) upper_zero = 1'b0;
      end
      if (idx_q != '0 && upper_zero) seg_d = SEG_BLANK;
    end
`endif
    idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
  end

  always_ff @(posedge clk_pi) begin
    if (rst_pi) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      samp_q    <= '0;
      tick_q    <= 1'b0;
      ref_q     <= '0;
      idx_q     <= '0;
      bin_lat_q <= '0;
      led_q     <= '0;
      disp_q    <= '0;
      anodo_q   <= '1;
      catodo_q  <= SEG_BLANK;
    end else begin
      sync1_q <= codigo_gray_pi;
      sync2_q <= sync1_q;
      samp_q  <= samp_q + SAMPLE_W'(1);
      tick_q  <= (samp_q == '1);
      ref_q   <= ref_q + REFRESH_W'(1);
      if (conv_start) bin_lat_q <= bin_now;
      // LEDs and display are loaded together so they never disagree
      if (state_q == S_LOAD) begin
        led_q  <= bin_lat_q;
        disp_q <= bcd_w;
      end
      if (ref_q == '1) begin
        anodo_q  <= ~(DIGITS'(1) << idx_q);
        catodo_q <= seg_d;
        idx_q    <= idx_d;
      end
    end
  end

  assign anodo_po          = anodo_q;
  assign catodo_po         = catodo_q;
  assign codigo_bin_led_po = led_q;
  assign conv_busy_po      = conv_busy || (state_q == S_LOAD);
  assign dato_listo_po     = (state_q == S_LOAD);

endmodule

// File: tb/tb_module_deco_gray_nseg.sv
// Bench for module_deco_gray_nseg with GRAY_W=4, DIGITS=2, REFRESH_W=3, SAMPLE_W=4.
module tb_module_deco_gray_nseg;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] gin = 4'd0;
  logic [1:0] anodo;
  logic [6:0] catodo;
  logic [3:0] led;
  logic       busy, listo;

  module_deco_gray_nseg #(.GRAY_W(4), .DIGITS(2), .REFRESH_W(3), .SAMPLE_W(4)) dut (
    .clk_pi            (clk),
    .rst_pi            (rst),
    .codigo_gray_pi    (gin),
    .anodo_po          (anodo),
    .catodo_po         (catodo),
    .codigo_bin_led_po (led),
    .conv_busy_po      (busy),
    .dato_listo_po     (listo)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  logic [6:0] SEGT [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  logic [3:0] GSEQ [0:15] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                              4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  function automatic int g2b(input logic [3:0] g);
    int gi;
    gi = int'(g);
    return gi ^ (gi >> 1) ^ (gi >> 2) ^ (gi >> 3);
  endfunction

  function automatic logic [6:0] digit_seg(input int v, input int k);
    int d;
    d = (k == 0) ? v % 10 : (v / 10) % 10;
`ifdef DECO_GRAY_BLANK_EN
    if (k > 0 && v < 10) return 7'h7F;
`endif
    return SEGT[d];
  endfunction

  // Model: n = clock edges since reset; sample every 16 edges, scan every 8, result visible 6 edges after a tick.
  int         n = 0;
  int         m_val, m_led, t_tick, v_pend, scan;
  logic [1:0] m_an;
  logic [6:0] m_cat;
  bit         m_busy, m_listo, act;

  always @(posedge clk) begin
    if (rst) begin
      n = 0; m_val = 0; m_led = 0; m_an = 2'b11; m_cat = 7'h7F;
      m_busy = 0; m_listo = 0; act = 0; scan = 0;
    end else begin
      n = n + 1;
      if (n % 8 == 0) begin
        m_an  = (scan == 0) ? 2'b10 : 2'b01;
        m_cat = digit_seg(m_val, scan);
        scan  = 1 - scan;
      end
      if (act) begin
        if (n == t_tick + 1) m_busy = 1;
        if (n == t_tick + 5) m_listo = 1;
        if (n == t_tick + 6) begin
          m_busy = 0; m_listo = 0; m_led = v_pend; m_val = v_pend; act = 0;
        end
      end
      if (n % 16 == 0 && !act) begin
        act = 1; t_tick = n; v_pend = g2b(gin);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_anodo", anodo, m_an);
      chk("m_catodo", catodo, m_cat);
      chk("m_led", led, m_led);
      chk("m_busy", busy, m_busy);
      chk("m_listo", listo, m_listo);
    end
  end

  task automatic wait_n(input int target);
    int b;
    b = 0;
    while (n != target && b < 2000) begin
      @(negedge clk);
      b++;
    end
    if (b >= 2000) begin
      tests++; fails++;
      $display("FAIL wait_n: cycle %0d never reached, at %0d", target, n);
    end
  endtask

  initial begin
    int lat;
    // Reset held three cycles
    @(negedge clk);
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_anodo", anodo, 2'b11);
    chk("rst_catodo", catodo, 7'h7F);
    chk("rst_led", led, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    gin = GSEQ[0];

    // Sweep all Gray codes, one per sample period
    for (int i = 0; i < 16; i++) begin
      wait_n(16 * (i + 1) + 7);
      chk("sweep_led", led, i);
      if (i < 15) gin = GSEQ[i + 1];
    end
    wait_n(265);
    chk("g1000_an0", anodo, 2'b10);
    chk("g1000_units", catodo, 7'h12);
    wait_n(273);
    chk("g1000_an1", anodo, 2'b01);
    chk("g1000_tens", catodo, 7'h79);

    // Tick-to-ready latency with Gray 0111
    gin = 4'b0111;
    wait_n(288);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!listo && lat < 20);
    chk("tick_to_listo", lat, 5);
    chk("led_before_load", led, 15);
    @(negedge clk);
    chk("led_after_load", led, 5);

    // Input change during conversion is ignored until the next tick
    wait_n(295);
    gin = 4'b1101;
    wait_n(307);
    chk("busy_mid_conv", busy, 1);
    gin = 4'b0010;
    wait_n(311);
    chk("latched_led", led, 9);
    wait_n(327);
    chk("next_tick_led", led, 3);

    // Reset on the second conversion cycle
    gin = 4'b1111;
    wait_n(338);
    chk("busy_before_rst", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_led", led, 0);
    chk("midrst_anodo", anodo, 2'b11);
    chk("midrst_catodo", catodo, 7'h7F);
    chk("midrst_listo", listo, 0);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("no_listo_after_rst", listo, 0);
    end
    wait_n(23);
    chk("post_rst_led", led, 10);

    // Gray 0101 -> 6: tens digit zero or blank, units 6
    gin = 4'b0101;
    wait_n(41);
    chk("six_an0", anodo, 2'b10);
    chk("six_units", catodo, 7'h02);
    wait_n(49);
    chk("six_an1", anodo, 2'b01);
`ifdef DECO_GRAY_BLANK_EN
    chk("six_tens", catodo, 7'h7F);
`else
    chk("six_tens", catodo, 7'h40);
`endif
    wait_n(57);
    chk("six_an0_again", anodo, 2'b10);
    chk("six_units_again", catodo, 7'h02);
    chk("six_led", led, 6);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
